clk_rate_ctrl: RTL
==================

CLK_RATE_CTRL -- requirements
Module: clk_rate_ctrl

Interface
REQ-001 Parameter: BASE_PERIOD, 32'd50_000_000, level-0 tick period in clk cycles; legal range 128 or more.
REQ-002 Parameter: DEFAULT_LEVEL, 3'd3, rate level loaded at reset.
REQ-003 Port: clk  in  1  single clock; all logic on posedge clk.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: btn_up  in  1  raw button, raise rate level.
REQ-006 Port: btn_down  in  1  raw button, lower rate level.
REQ-007 Port: btn_mode  in  1  raw button, run/pause toggle.
REQ-008 Port: btn_step  in  1  raw button, single tick when paused.
REQ-009 Port: level  out  3  current rate level, 0..7.
REQ-010 Port: period  out  32  applied period, BASE_PERIOD >> applied level.
REQ-011 Port: running  out  1  high only in state RUN.
REQ-012 Port: tick  out  1  one-cycle pulse at each period boundary.
REQ-013 Port: tick_cnt  out  16  count of ticks emitted since reset.

Function
REQ-014 Each btn_* shall pass through its own 2-FF rising-edge detector; a press sampled high at edge k gives an internal pulse at edge k+1, and its effect shall be visible on outputs after edge k+2.
REQ-015 FSM states shall be PAUSE, RUN and STEP, with the following transitions:
- PAUSE+mode goes to RUN;
- PAUSE+step goes to STEP;
- RUN+mode goes to PAUSE;
- STEP+mode goes to RUN, keeping the current count;
- STEP goes to PAUSE on the cycle its tick fires;
- step in RUN or STEP is ignored;
- mode has priority over step when both pulse together.
REQ-016 Up pulse: level+1, saturating at 7. Down pulse: level-1, saturating at 0. Up and down in the same cycle: no change.
REQ-017 In PAUSE, a level change shall update period in the same cycle as level. In RUN or STEP, the new period shall be held pending and applied only at the next count reload, so no truncated or stretched period ever occurs.
REQ-018 Count register, 32 bits:
- loads period-1 on any PAUSE-to-RUN or PAUSE-to-STEP transition;
- decrements each cycle in RUN or STEP;
- at 0, asserts tick for exactly that cycle and reloads with (pending period)-1.
REQ-019 Period 1 (level 7 with BASE_PERIOD=128) shall give tick on every cycle in RUN.
REQ-020 Entering PAUSE shall freeze count. The next RUN or STEP reloads count, so the partial period is discarded and no tick is emitted on the pause cycle.
REQ-021 tick_cnt shall increment on each tick and wrap from 16'hFFFF to 0 with no flag.
REQ-022 tick shall never assert in PAUSE.

Reset
REQ-023 On rst, sampled at posedge clk, the following shall be set on the next cycle:
- state to PAUSE; level to DEFAULT_LEVEL; period to BASE_PERIOD>>DEFAULT_LEVEL;
- count to 0; tick, tick_cnt and running to 0; pending period cleared.
REQ-024 On rst, edge-detector flops shall load 1, so a button held through reset produces no pulse until released and pressed again.
REQ-025 rst mid-RUN or mid-STEP shall abort immediately with no tick in the reset cycle or the cycle after it.

Structure
REQ-026 Package clk_rate_pkg shall hold the FSM state enum, NUM_LEVELS=8 and LEVEL_W=3.
REQ-027 Sub-module btn_edge (2-FF rising-edge pulse, synchronous reset to 1) shall be instantiated four times. The period/count datapath stays in clk_rate_ctrl.

Verification (BASE_PERIOD=128, DEFAULT_LEVEL=3)
REQ-028 Reset: after rst, level=3, period=16, running=0, tick=0, tick_cnt=0. Holding btn_up through the reset deassert leaves level=3.
REQ-029 Press btn_mode: running rises 2 cycles later. Ticks then occur every 16 cycles with the first 16 cycles after entry; after 3 ticks, tick_cnt=3.
REQ-030 In RUN, press btn_up 5 cycles after a tick:
- level=4 immediately, period stays 16 until the next tick;
- the next interval is still 16 cycles, then intervals are 8.
REQ-031 Press btn_up 6 times from level 3: level saturates at 7 and period=1, with tick every cycle in RUN. Simultaneous up+down leaves level unchanged.
REQ-032 In PAUSE, press btn_step: exactly one tick 16 cycles after entry, then state returns to PAUSE. Pressing step in RUN changes nothing.
REQ-033 Assert rst 4 cycles before an expected tick in RUN: no tick occurs and all outputs take their reset values. Force 65536 ticks: tick_cnt wraps to 0.

Source files
------------

// File: rtl/clk_rate_pkg.sv
// Shared types and constants for the tick-rate controller.
// Holds the FSM state encoding, the level range and the level-to-period mapping.
package clk_rate_pkg;

  localparam int NUM_LEVELS = 8;
  localparam int LEVEL_W    = 3;

  localparam logic [LEVEL_W-1:0] LEVEL_MIN = '0;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2
  } state_t;

  // Each level halves the tick period relative to the one below it.
  function automatic logic [31:0] level_period(input logic [31:0] base,
                                               input logic [LEVEL_W-1:0] lvl);
    return base >> lvl;
  endfunction

endpackage

// File: rtl/clk_rate_ctrl_btn_edge.sv
// Rising-edge detector for one raw push button: two sampling flops plus a
// registered one-cycle pulse. Flops preset to 1 so a held button never fires.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync_q;
  logic prev_q;

  // NOTE: every flop here uses <= so all three sample the old values together;
  // a blocking = would collapse the pipeline and lose the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      pulse  <= 1'b0;
    end else begin
      sync_q <= btn;
      prev_q <= sync_q;
      pulse  <= sync_q & ~prev_q;
    end
  end

endmodule

// File: rtl/clk_rate_ctrl.sv
// Adjustable-rate tick generator with run/pause/single-step control from four
// push buttons. Rate changes while counting wait for the next period boundary.
module clk_rate_ctrl
  import clk_rate_pkg::*;
#(
  parameter logic [31:0]        BASE_PERIOD   = 32'd50_000_000,
  parameter logic [LEVEL_W-1:0] DEFAULT_LEVEL = 3'd3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_mode,
  input  logic               btn_step,
  output logic [LEVEL_W-1:0] level,
  output logic [31:0]        period,
  output logic               running,
  output logic               tick,
  output logic [15:0]        tick_cnt
);

  logic up_p;
  logic down_p;
  logic mode_p;
  logic step_p;

  btn_edge u_edge_up   (.clk(clk), .rst(rst), .btn(btn_up),   .pulse(up_p));
  btn_edge u_edge_down (.clk(clk), .rst(rst), .btn(btn_down), .pulse(down_p));
  btn_edge u_edge_mode (.clk(clk), .rst(rst), .btn(btn_mode), .pulse(mode_p));
  btn_edge u_edge_step (.clk(clk), .rst(rst), .btn(btn_step), .pulse(step_p));

  state_t       state;
  logic [31:0]  count;
  logic [31:0]  pend_period;
  logic         pend_valid;

  logic [LEVEL_W-1:0] lvl_nxt;
  logic               lvl_chg;
  logic [31:0]        lvl_period;
  logic [31:0]        reload_period;
  logic               do_count;
  logic               do_tick;
  logic               to_pause;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    lvl_nxt       = level;
    do_count      = 1'b0;
    do_tick       = 1'b0;
    to_pause      = 1'b0;

    if (up_p && !down_p && level != LEVEL_MAX) begin
      lvl_nxt = level + 1'b1;
    end else if (down_p && !up_p && level != LEVEL_MIN) begin
      lvl_nxt = level - 1'b1;
    end

    // mode wins over the step tick, so STEP+mode keeps counting into RUN
    unique case (state)
      RUN: begin
        do_count = !mode_p;
        to_pause = mode_p;
      end
      STEP: begin
        do_count = 1'b1;
        to_pause = !mode_p && (count == '0);
      end
      default: ;
    endcase

    do_tick = do_count && (count == '0);
  end

  assign lvl_chg       = (lvl_nxt != level);
  assign lvl_period    = level_period(BASE_PERIOD, lvl_nxt);
  assign reload_period = pend_valid ? pend_period : period;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PAUSE;
      level       <= DEFAULT_LEVEL;
      period      <= level_period(BASE_PERIOD, DEFAULT_LEVEL);
      pend_period <= '0;
      pend_valid  <= 1'b0;
      count       <= '0;
      tick        <= 1'b0;
      tick_cnt    <= '0;
      running     <= 1'b0;
    end else begin
      level <= lvl_nxt;
      tick  <= 1'b0;

      case (state)
        PAUSE: begin
          // idle: the applied period follows the level directly
          period <= lvl_period;
          if (mode_p) begin
            state   <= RUN;
            running <= 1'b1;
            count   <= lvl_period - 32'd1;
          end else if (step_p) begin
            state   <= STEP;
            count   <= lvl_period - 32'd1;
          end
        end

        RUN, STEP: begin
          if (do_tick) begin
            tick     <= 1'b1;
            tick_cnt <= tick_cnt + 16'd1;
            count    <= reload_period - 32'd1;
          end else if (do_count) begin
            count    <= count - 32'd1;
          end

          if (to_pause) begin
            // count stays frozen; any deferred rate change lands now
            state      <= PAUSE;
            running    <= 1'b0;
            period     <= lvl_period;
            pend_valid <= 1'b0;
          end else begin
            if (mode_p) begin
              state   <= RUN;
              running <= 1'b1;
            end
            if (do_tick) begin
              period     <= reload_period;
              pend_valid <= 1'b0;
            end
            if (lvl_chg) begin
              pend_period <= lvl_period;
              pend_valid  <= 1'b1;
            end
          end
        end

        default: begin
          state   <= PAUSE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
